// File: rtl/obj_bbox_pkg.sv
// Shared types and constants for the object bounding-box tracker.
package obj_bbox_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESULT} state_t;

  // Accumulator coordinate width; must cover the largest CW in use.
  localparam int unsigned BBOX_CW = 16;

  localparam logic [23:0] OVERLAY_RGB = 24'hFF0000;

  typedef struct packed {
    logic [BBOX_CW-1:0] x0;
    logic [BBOX_CW-1:0] y0;
    logic [BBOX_CW-1:0] x1;
    logic [BBOX_CW-1:0] y1;
  } bbox_t;

endpackage

// File: rtl/hv_counter.sv
// Pixel coordinate generator: saturating hcnt/vcnt driven by de, plus vsync rising-edge detect.
module hv_counter #(
  parameter int unsigned IMG_W = 200,
  parameter int unsigned IMG_H = 164,
  parameter int unsigned CW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          de,
  input  logic          vsync,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          vs_rise_c,
  output logic          pix_ok_c,
  output logic          last_c
);

  localparam logic [CW-1:0] H_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] V_MAX = CW'(IMG_H - 1);

  logic de_d;
  logic vs_d;
  logic h_full;
  logic v_full;
  logic run_c;

  assign vs_rise_c = vsync & ~vs_d;
  assign run_c     = en & ~vs_rise_c;
  assign pix_ok_c  = run_c & de & ~h_full & ~v_full;
  assign last_c    = pix_ok_c & (hcnt == H_MAX) & (vcnt == V_MAX);

  // h_full/v_full mark that the last legal column/line was consumed; later pixels are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_d   <= 1'b0;
      vs_d   <= 1'b0;
      hcnt   <= '0;
      vcnt   <= '0;
      h_full <= 1'b0;
      v_full <= 1'b0;
    end else begin
      de_d <= de;
      vs_d <= vsync;
      if (!run_c) begin
        hcnt   <= '0;
        vcnt   <= '0;
        h_full <= 1'b0;
        v_full <= 1'b0;
      end else begin
        if (!de) begin
          hcnt   <= '0;
          h_full <= 1'b0;
        end else if (!h_full) begin
          if (hcnt == H_MAX) h_full <= 1'b1;
          else               hcnt   <= hcnt + CW'(1);
        end
        if (de_d && !de) begin
          if (vcnt == V_MAX) v_full <= 1'b1;
          else               vcnt   <= vcnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/obj_bbox_track.sv
// Tracks the bounding box, center and pixel count of foreground pixels per video frame.
// Optional red box/center overlay on the video output when BBOX_OVERLAY_EN is defined.
module obj_bbox_track
  import obj_bbox_pkg::*;
#(
  parameter int unsigned IMG_W   = 200,
  parameter int unsigned IMG_H   = 164,
  parameter int unsigned DW      = 24,
  parameter int unsigned CW      = 12,
  parameter int unsigned FG_POL  = 0,
  parameter int unsigned MIN_PIX = 500
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   i_binary,
  input  logic            i_hsync,
  input  logic            i_vsync,
  input  logic            i_de,
  output logic [DW-1:0]   o_binary,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_de,
  output logic [CW-1:0]   o_x0,
  output logic [CW-1:0]   o_y0,
  output logic [CW-1:0]   o_x1,
  output logic [CW-1:0]   o_y1,
  output logic [CW-1:0]   o_cx,
  output logic [CW-1:0]   o_cy,
  output logic [2*CW-1:0] o_pix_cnt,
  output logic [2*CW-1:0] o_box_area,
  output logic            o_valid,
  output logic            o_found
);

  localparam bbox_t ACC_CLR = '{x0: {BBOX_CW{1'b1}}, y0: {BBOX_CW{1'b1}},
                                x1: {BBOX_CW{1'b0}}, y1: {BBOX_CW{1'b0}}};

  state_t            state;
  bbox_t             acc;
  logic [2*CW-1:0]   cnt;
  logic [CW-1:0]     hcnt;
  logic [CW-1:0]     vcnt;
  logic              vs_rise_c;
  logic              pix_ok_c;
  logic              last_c;
  logic              fg_c;
  logic [DW-1:0]     pix_out_c;
  logic [BBOX_CW-1:0] hx_c;
  logic [BBOX_CW-1:0] vy_c;

  hv_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) u_hv (
    .clk       (clk),
    .rst       (rst),
    .en        (state == ACTIVE),
    .de        (i_de),
    .vsync     (i_vsync),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .vs_rise_c (vs_rise_c),
    .pix_ok_c  (pix_ok_c),
    .last_c    (last_c)
  );

  assign fg_c = (FG_POL != 0) ? (&i_binary) : ~(|i_binary);
  assign hx_c = BBOX_CW'(hcnt);
  assign vy_c = BBOX_CW'(vcnt);

  // Result arithmetic from the accumulated box.
  logic [CW-1:0]     bx0_c, by0_c, bx1_c, by1_c;
  logic [CW:0]       sum_x_c, sum_y_c, w_c, h_c;
  logic [2*CW+1:0]   area_full_c;
  logic              found_c;

  always_comb begin
    bx0_c       = CW'(acc.x0);
    by0_c       = CW'(acc.y0);
    bx1_c       = CW'(acc.x1);
    by1_c       = CW'(acc.y1);
    sum_x_c     = {1'b0, bx0_c} + {1'b0, bx1_c};
    sum_y_c     = {1'b0, by0_c} + {1'b0, by1_c};
    w_c         = {1'b0, bx1_c} - {1'b0, bx0_c} + (CW+1)'(1);
    h_c         = {1'b0, by1_c} - {1'b0, by0_c} + (CW+1)'(1);
    area_full_c = (2*CW+2)'(w_c) * (2*CW+2)'(h_c);
    found_c     = (cnt >= (2*CW)'(MIN_PIX));
  end

`ifdef BBOX_OVERLAY_EN
  localparam logic [DW+23:0] RED_EXT = {OVERLAY_RGB, {DW{1'b0}}};
  localparam logic [DW-1:0]  RED     = RED_EXT[DW+23 -: DW];

  logic in_x_c, in_y_c, hit_c;

  // Overlay uses the previously registered result against the current pixel position.
  always_comb begin
    in_x_c    = (hcnt >= o_x0) && (hcnt <= o_x1);
    in_y_c    = (vcnt >= o_y0) && (vcnt <= o_y1);
    hit_c     = pix_ok_c && o_found &&
                ((in_x_c && ((vcnt == o_y0) || (vcnt == o_y1))) ||
                 (in_y_c && ((hcnt == o_x0) || (hcnt == o_x1))) ||
                 ((hcnt == o_cx) && (vcnt == o_cy)));
    pix_out_c = hit_c ? RED : i_binary;
  end
`else
  assign pix_out_c = i_binary;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= ACC_CLR;
      cnt        <= '0;
      o_binary   <= '0;
      o_hsync    <= 1'b0;
      o_vsync    <= 1'b0;
      o_de       <= 1'b0;
      o_x0       <= '0;
      o_y0       <= '0;
      o_x1       <= '0;
      o_y1       <= '0;
      o_cx       <= '0;
      o_cy       <= '0;
      o_pix_cnt  <= '0;
      o_box_area <= '0;
      o_valid    <= 1'b0;
      o_found    <= 1'b0;
    end else begin
      o_binary <= pix_out_c;
      o_hsync  <= i_hsync;
      o_vsync  <= i_vsync;
      o_de     <= i_de;
      o_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (vs_rise_c) begin
            acc   <= ACC_CLR;
            cnt   <= '0;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (vs_rise_c) begin
            acc <= ACC_CLR;
            cnt <= '0;
          end else begin
            if (pix_ok_c && fg_c) begin
              if (cnt != {2*CW{1'b1}}) cnt <= cnt + (2*CW)'(1);
              if (hx_c < acc.x0) acc.x0 <= hx_c;
              if (hx_c > acc.x1) acc.x1 <= hx_c;
              if (vy_c < acc.y0) acc.y0 <= vy_c;
              if (vy_c > acc.y1) acc.y1 <= vy_c;
            end
            if (last_c) state <= RESULT;
          end
        end
        RESULT: begin
          o_valid    <= 1'b1;
          o_found    <= found_c;
          o_pix_cnt  <= cnt;
          o_x0       <= found_c ? bx0_c : '0;
          o_y0       <= found_c ? by0_c : '0;
          o_x1       <= found_c ? bx1_c : '0;
          o_y1       <= found_c ? by1_c : '0;
          o_cx       <= found_c ? sum_x_c[CW:1] : '0;
          o_cy       <= found_c ? sum_y_c[CW:1] : '0;
          o_box_area <= found_c ? area_full_c[2*CW-1:0] : '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_bbox_track.sv
// Randomized scoreboard bench for obj_bbox_track with a frame-level reference model.
module tb_obj_bbox_track;

  localparam int unsigned W    = 64;
  localparam int unsigned H    = 48;
  localparam int unsigned DW   = 24;
  localparam int unsigned CW   = 12;
  localparam int unsigned MINP = 120;
  localparam logic [DW-1:0] RED = 24'hFF0000;

  typedef struct {
    bit found;
    int x0, y0, x1, y1, cx, cy, cnt, area;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] i_binary = '0;
  logic i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0;
  logic [DW-1:0] o_binary;
  logic o_hsync, o_vsync, o_de;
  logic [CW-1:0] o_x0, o_y0, o_x1, o_y1, o_cx, o_cy;
  logic [2*CW-1:0] o_pix_cnt, o_box_area;
  logic o_valid, o_found;

  always #5 clk = ~clk;

  obj_bbox_track #(.IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW), .FG_POL(0), .MIN_PIX(MINP)) dut (
    .clk(clk), .rst(rst), .i_binary(i_binary), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_de(i_de), .o_binary(o_binary), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .o_x0(o_x0), .o_y0(o_y0), .o_x1(o_x1), .o_y1(o_y1), .o_cx(o_cx), .o_cy(o_cy),
    .o_pix_cnt(o_pix_cnt), .o_box_area(o_box_area), .o_valid(o_valid), .o_found(o_found)
  );

  int n_cmp = 0, n_err = 0, n_pushed = 0, n_got = 0;
  bit img [H][W];
  res_t q[$];
  res_t pend, last_res, mon_e;
  bit in_frame = 1'b0;
  logic [DW-1:0] exp_bin = '0;
  logic [DW-1:0] m_eb;
  logic m_hs, m_vs, m_de, m_rst;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: scan the intended image and apply the result rules directly.
  function automatic res_t compute();
    res_t r;
    int mnx = W, mny = H, mxx = -1, mxy = -1, c = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (img[y][x]) begin
          c++;
          if (x < mnx) mnx = x;
          if (x > mxx) mxx = x;
          if (y < mny) mny = y;
          if (y > mxy) mxy = y;
        end
    r.cnt = c;
    r.found = (c >= MINP);
    if (r.found) begin
      r.x0 = mnx; r.y0 = mny; r.x1 = mxx; r.y1 = mxy;
      r.cx = (mnx + mxx) / 2; r.cy = (mny + mxy) / 2;
      r.area = (mxx - mnx + 1) * (mxy - mny + 1);
    end else begin
      r.x0 = 0; r.y0 = 0; r.x1 = 0; r.y1 = 0; r.cx = 0; r.cy = 0; r.area = 0;
    end
    return r;
  endfunction

  function automatic bit ovl_hit(input int x, input int y);
    bit hit;
    hit = in_frame && last_res.found && x < W && y < H &&
          (((x >= last_res.x0 && x <= last_res.x1) && (y == last_res.y0 || y == last_res.y1)) ||
           ((y >= last_res.y0 && y <= last_res.y1) && (x == last_res.x0 || x == last_res.x1)) ||
           (x == last_res.cx && y == last_res.cy));
`ifndef BBOX_OVERLAY_EN
    hit = 1'b0;
`endif
    return hit;
  endfunction

  function automatic logic [DW-1:0] nonfg();
    logic [DW-1:0] v;
    v = DW'($urandom);
    if (v == '0) v = DW'(1);
    return v;
  endfunction

  task automatic clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 1'b0;
  endtask

  task automatic fill_rect(input int x0, input int y0, input int x1, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) img[y][x] = 1'b1;
  endtask

  task automatic cyc(input logic [DW-1:0] b, input logic hs, input logic vs, input logic de,
                     input bit ovl);
    @(posedge clk);
    #1;
    i_binary = b; i_hsync = hs; i_vsync = vs; i_de = de;
    exp_bin = ovl ? RED : b;
  endtask

  task automatic drive_line(input int y, input int nx);
    bit fg, hit;
    cyc(nonfg(), 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(nonfg(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int x = 0; x < nx; x++) begin
      if (x < W && y < H) fg = img[y][x];
      else                fg = ($urandom_range(0, 3) == 0);
      hit = ovl_hit(x, y);
      cyc(fg ? '0 : nonfg(), 1'b0, 1'b0, 1'b1, hit);
      if (in_frame && x == W - 1 && y == H - 1) in_frame = 1'b0;
    end
    cyc(nonfg(), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(nonfg(), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_frame(input int y_start, input int y_end, input bit vs, input int nx,
                             input bit expect_res);
    if (vs) begin
      cyc(nonfg(), 1'b0, 1'b1, 1'b0, 1'b0);
      in_frame = 1'b1;
      cyc(nonfg(), 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(nonfg(), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (expect_res) begin
      pend = compute();
      q.push_back(pend);
      n_pushed++;
    end
    for (int y = y_start; y < y_end; y++) drive_line(y, nx);
    if (expect_res) last_res = pend;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, longint'(o_valid), 0);
    chk({tag, "_found"}, longint'(o_found), 0);
    chk({tag, "_box"}, longint'({o_x0, o_y0, o_x1, o_y1}), 0);
    chk({tag, "_center"}, longint'({o_cx, o_cy}), 0);
    chk({tag, "_pix_cnt"}, longint'(o_pix_cnt), 0);
    chk({tag, "_area"}, longint'(o_box_area), 0);
    chk({tag, "_video"}, longint'({o_binary, o_hsync, o_vsync, o_de}), 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    in_frame = 1'b0;
    last_res.found = 1'b0;
    @(negedge clk);
    check_zero("midrst");
  endtask

  // Video monitor: output must equal the previous cycle's input (or overlay / reset value).
  initial begin
    forever begin
      @(posedge clk);
      m_rst = rst; m_eb = exp_bin; m_hs = i_hsync; m_vs = i_vsync; m_de = i_de;
      @(negedge clk);
      if (m_rst) chk("video_rst", longint'({o_binary, o_hsync, o_vsync, o_de}), 0);
      else chk("video", longint'({o_binary, o_hsync, o_vsync, o_de}),
               longint'({m_eb, m_hs, m_vs, m_de}));
    end
  end

  // Result monitor: every o_valid consumes one expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        n_got++;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got o_valid=1 required no result at %0t", $time);
        end else begin
          mon_e = q.pop_front();
          chk("found", longint'(o_found), longint'(mon_e.found));
          chk("x0", longint'(o_x0), mon_e.x0);
          chk("y0", longint'(o_y0), mon_e.y0);
          chk("x1", longint'(o_x1), mon_e.x1);
          chk("y1", longint'(o_y1), mon_e.y1);
          chk("cx", longint'(o_cx), mon_e.cx);
          chk("cy", longint'(o_cy), mon_e.cy);
          chk("pix_cnt", longint'(o_pix_cnt), mon_e.cnt);
          chk("box_area", longint'(o_box_area), mon_e.area);
        end
      end
    end
  end

  initial begin
    int rx0, ry0, rx1, ry1;
    last_res.found = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Found object, then a too-small one on the same frame layout.
    clear_img(); fill_rect(10, 8, 29, 19);
    drive_frame(0, H, 1'b1, W, 1'b1);
    clear_img(); fill_rect(10, 8, 19, 17);
    drive_frame(0, H, 1'b1, W, 1'b1);

    // Extreme corner coordinates plus a block.
    clear_img(); img[0][0] = 1'b1; img[H-1][W-1] = 1'b1; fill_rect(20, 15, 44, 34);
    drive_frame(0, H, 1'b1, W, 1'b1);

    // Frame abandoned by a vsync at line 24, followed by a full frame.
    clear_img(); fill_rect(5, 5, 40, 30);
    drive_frame(0, 24, 1'b1, W, 1'b0);
    clear_img(); fill_rect(30, 20, 49, 29);
    drive_frame(0, H, 1'b1, W, 1'b1);

    // Reset in the middle of a frame; the rest of that frame must yield nothing.
    clear_img(); fill_rect(0, 0, 30, 30);
    drive_frame(0, 20, 1'b1, W, 1'b0);
    mid_reset();
    drive_frame(20, H, 1'b0, W, 1'b0);
    clear_img(); fill_rect(40, 10, 59, 25);
    drive_frame(0, H, 1'b1, W, 1'b1);

    // Random objects with noise, overlong lines and extra lines beyond the limits.
    for (int f = 0; f < 4; f++) begin
      clear_img();
      rx0 = $urandom_range(0, W - 1); rx1 = $urandom_range(rx0, W - 1);
      ry0 = $urandom_range(0, H - 1); ry1 = $urandom_range(ry0, H - 1);
      fill_rect(rx0, ry0, rx1, ry1);
      for (int k = 0; k < 6; k++) img[$urandom_range(0, H - 1)][$urandom_range(0, W - 1)] = 1'b1;
      drive_frame(0, H + $urandom_range(0, 2), 1'b1, W + $urandom_range(0, 3), 1'b1);
    end

    repeat (20) @(posedge clk);
    chk("results_seen", n_got, n_pushed);
    chk("results_pending", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
